// File: rtl/omi_protocol_monitor.sv
// omi_protocol_monitor
//   Passive checker for NUM_CH independent OMI links. It follows each transaction
//   through request, handshake and read-data beats, latches protocol violations
//   and counts completed transactions. It never drives the observed links.
// Ports
//   clk, reset_n   clock, asynchronous active-low reset
//   i_req/i_addr/i_wen/i_ben/i_data/i_len/i_rdy/i_valid   observed link signals,
//                  channel k in slice k of each packed bus
//   i_clr_err      clears the sticky flags and the first-error record
//   o_err_vec      sticky per-channel error flags
//   o_err_valid/o_err_ch/o_err_code   first error seen since reset or clear
//   o_busy         channel has a request pending or read data outstanding
//   o_txn_cnt      saturating count of completed transactions
module omi_protocol_monitor #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MAX_LEN      = 2,
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned CHECK_STABLE = 1,
  localparam int unsigned BenW = DATA_WIDTH / 8,
  localparam int unsigned ChW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH-1:0]            i_req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] i_addr,
  input  logic [NUM_CH-1:0]            i_wen,
  input  logic [NUM_CH*BenW-1:0]       i_ben,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_CH*8-1:0]          i_len,
  input  logic [NUM_CH-1:0]            i_rdy,
  input  logic [NUM_CH-1:0]            i_valid,
  input  logic                         i_clr_err,
  output logic [NUM_CH-1:0]            o_err_vec,
  output logic                         o_err_valid,
  output logic [ChW-1:0]               o_err_ch,
  output logic [2:0]                   o_err_code,
  output logic [NUM_CH-1:0]            o_busy,
  output logic [15:0]                  o_txn_cnt
);

  localparam int unsigned AlignW = $clog2(BenW);
  localparam int unsigned CntW   = $clog2(TIMEOUT + 1);
  localparam int unsigned BeatW  = 9;
  localparam int unsigned DoneW  = $clog2(NUM_CH + 1);

  typedef enum logic [1:0] {StIdle, StPend, StResp} ch_state_e;

  ch_state_e              state_q    [NUM_CH];
  ch_state_e              state_d    [NUM_CH];
  logic [BeatW-1:0]       beats_q    [NUM_CH];
  logic [BeatW-1:0]       beats_d    [NUM_CH];
  logic [CntW-1:0]        prog_q     [NUM_CH];
  logic [CntW-1:0]        prog_d     [NUM_CH];
  logic [ADDR_WIDTH-1:0]  cap_addr_q [NUM_CH];
  logic [ADDR_WIDTH-1:0]  cap_addr_d [NUM_CH];
  logic                   cap_wen_q  [NUM_CH];
  logic                   cap_wen_d  [NUM_CH];
  logic [BenW-1:0]        cap_ben_q  [NUM_CH];
  logic [BenW-1:0]        cap_ben_d  [NUM_CH];
  logic [DATA_WIDTH-1:0]  cap_data_q [NUM_CH];
  logic [DATA_WIDTH-1:0]  cap_data_d [NUM_CH];
  logic [7:0]             cap_len_q  [NUM_CH];
  logic [7:0]             cap_len_d  [NUM_CH];

  logic [ADDR_WIDTH-1:0]  addr_w     [NUM_CH];
  logic [BenW-1:0]        ben_w      [NUM_CH];
  logic [DATA_WIDTH-1:0]  data_w     [NUM_CH];
  logic [7:0]             len_w      [NUM_CH];
  logic [7:1]             err_flags  [NUM_CH];
  logic [2:0]             ch_code    [NUM_CH];
  logic [NUM_CH-1:0]      ch_err;
  logic [NUM_CH-1:0]      ch_done;

  logic [NUM_CH-1:0]      err_vec_q, err_vec_d;
  logic                   err_valid_q, err_valid_d;
  logic [ChW-1:0]         err_ch_q, err_ch_d;
  logic [2:0]             err_code_q, err_code_d;
  logic [15:0]            txn_q, txn_d;
  logic [ChW-1:0]         first_ch;
  logic [DoneW-1:0]       done_cnt;
  logic [16:0]            txn_sum;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      addr_w[k] = i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      ben_w[k]  = i_ben[k*BenW +: BenW];
      data_w[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
      len_w[k]  = i_len[k*8 +: 8];
    end
  end

  // Per-channel transaction tracking and violation detection.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      state_d[k]    = state_q[k];
      beats_d[k]    = beats_q[k];
      prog_d[k]     = '0;
      cap_addr_d[k] = cap_addr_q[k];
      cap_wen_d[k]  = cap_wen_q[k];
      cap_ben_d[k]  = cap_ben_q[k];
      cap_data_d[k] = cap_data_q[k];
      cap_len_d[k]  = cap_len_q[k];
      err_flags[k]  = '0;
      ch_done[k]    = 1'b0;

      err_flags[k][3] = i_rdy[k] && !i_req[k];
      err_flags[k][4] = i_req[k] && (addr_w[k][AlignW-1:0] != '0);
      err_flags[k][5] = i_req[k] && (32'(len_w[k]) > MAX_LEN);
      // Valid outside RESP also covers a beat on the handshake cycle itself.
      err_flags[k][6] = (i_valid[k] && (state_q[k] != StResp)) ||
                        (i_req[k] && (state_q[k] == StResp));

      unique case (state_q[k])
        StIdle: begin
          if (i_req[k]) begin
            if (!i_rdy[k]) begin
              state_d[k]    = StPend;
              cap_addr_d[k] = addr_w[k];
              cap_wen_d[k]  = i_wen[k];
              cap_ben_d[k]  = ben_w[k];
              cap_data_d[k] = data_w[k];
              cap_len_d[k]  = len_w[k];
            end else if (i_wen[k]) begin
              ch_done[k] = 1'b1;
            end else begin
              state_d[k] = StResp;
              beats_d[k] = {1'b0, len_w[k]} + BeatW'(1);
            end
          end
        end
        StPend: begin
          if ((CHECK_STABLE != 0) &&
              ((addr_w[k] != cap_addr_q[k]) || (i_wen[k] != cap_wen_q[k]) ||
               (len_w[k] != cap_len_q[k]) || (data_w[k] != cap_data_q[k]) ||
               (i_wen[k] && (ben_w[k] != cap_ben_q[k])))) begin
            err_flags[k][2] = 1'b1;
          end
          if (!i_req[k]) begin
            err_flags[k][1] = 1'b1;
            state_d[k]      = StIdle;
          end else if (i_rdy[k]) begin
            // A handshake is progress, so it beats a same-cycle timeout.
            if (cap_wen_q[k]) begin
              ch_done[k] = 1'b1;
              state_d[k] = StIdle;
            end else begin
              state_d[k] = StResp;
              beats_d[k] = {1'b0, cap_len_q[k]} + BeatW'(1);
            end
          end else if (prog_q[k] == CntW'(TIMEOUT - 1)) begin
            err_flags[k][7] = 1'b1;
            state_d[k]      = StIdle;
          end else begin
            prog_d[k] = prog_q[k] + CntW'(1);
          end
        end
        StResp: begin
          if (i_valid[k]) begin
            if (beats_q[k] == BeatW'(1)) begin
              ch_done[k] = 1'b1;
              state_d[k] = StIdle;
            end else begin
              beats_d[k] = beats_q[k] - BeatW'(1);
            end
          end else if (prog_q[k] == CntW'(TIMEOUT - 1)) begin
            err_flags[k][7] = 1'b1;
            state_d[k]      = StIdle;
          end else begin
            prog_d[k] = prog_q[k] + CntW'(1);
          end
        end
        default: state_d[k] = StIdle;
      endcase

      // Lowest code wins within a channel.
      ch_code[k] = '0;
      for (int c = 7; c >= 1; c--) begin
        if (err_flags[k][c]) ch_code[k] = 3'(c);
      end
      ch_err[k] = |err_flags[k];
    end
  end

  // Error record and transaction counter.
  always_comb begin
    first_ch = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (ch_err[k]) first_ch = ChW'(k);
    end
    err_vec_d   = (i_clr_err ? '0 : err_vec_q) | ch_err;
    err_valid_d = err_valid_q;
    err_ch_d    = err_ch_q;
    err_code_d  = err_code_q;
    // A clear and a new error in the same cycle leave the new error recorded.
    if (|ch_err && (!err_valid_q || i_clr_err)) begin
      err_valid_d = 1'b1;
      err_ch_d    = first_ch;
      err_code_d  = ch_code[first_ch];
    end else if (i_clr_err) begin
      err_valid_d = 1'b0;
      err_ch_d    = '0;
      err_code_d  = '0;
    end
    done_cnt = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      done_cnt = done_cnt + DoneW'(ch_done[k]);
    end
    txn_sum = {1'b0, txn_q} + 17'(done_cnt);
    txn_d   = txn_sum[16] ? 16'hFFFF : txn_sum[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k]    <= StIdle;
        beats_q[k]    <= '0;
        prog_q[k]     <= '0;
        cap_addr_q[k] <= '0;
        cap_wen_q[k]  <= 1'b0;
        cap_ben_q[k]  <= '0;
        cap_data_q[k] <= '0;
        cap_len_q[k]  <= '0;
      end
      err_vec_q   <= '0;
      err_valid_q <= 1'b0;
      err_ch_q    <= '0;
      err_code_q  <= '0;
      txn_q       <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k]    <= state_d[k];
        beats_q[k]    <= beats_d[k];
        prog_q[k]     <= prog_d[k];
        cap_addr_q[k] <= cap_addr_d[k];
        cap_wen_q[k]  <= cap_wen_d[k];
        cap_ben_q[k]  <= cap_ben_d[k];
        cap_data_q[k] <= cap_data_d[k];
        cap_len_q[k]  <= cap_len_d[k];
      end
      err_vec_q   <= err_vec_d;
      err_valid_q <= err_valid_d;
      err_ch_q    <= err_ch_d;
      err_code_q  <= err_code_d;
      txn_q       <= txn_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      o_busy[k] = (state_q[k] != StIdle);
    end
  end

  assign o_err_vec   = err_vec_q;
  assign o_err_valid = err_valid_q;
  assign o_err_ch    = err_ch_q;
  assign o_err_code  = err_code_q;
  assign o_txn_cnt   = txn_q;

endmodule
